alu: RTL and testbench
======================

# alu

Parameterized integer ALU for the TP1 datapath. It takes two NBITS operands and a 6-bit MIPS-style function code, and computes one of eight arithmetic, logic or shift operations. The result is registered on `clk`, with asynchronous active-high `reset`. The block sits between the operand/opcode input registers and whatever consumes the result, such as display LEDs or a downstream register.

## Interface
Parameters:
- `NBITS`, default 8: width of both operands and of the result.
- `COD_OP`, default 6: width of the operation code.

Ports:
- `clk`  input  1: single system clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high; clears the result register.
- `operando_A`  input  NBITS: first operand, and the value shifted by shift operations.
- `operando_B`  input  NBITS: second operand, and the shift amount for shift operations.
- `cod_operacion`  input  COD_OP: operation select (function code).
- `ALU_Result`  output  NBITS: registered result.

## Operation
The function codes below are binary, decoded on all 6 bits:
- `100000` ADD: A + B, modulo 2^NBITS; carry discarded.
- `100010` SUB: A − B, modulo 2^NBITS (two's complement wrap).
- `100100` AND: A & B.
- `100101` OR: A | B.
- `100110` XOR: A ^ B.
- `100111` NOR: ~(A | B).
- `000011` SRA: A shifted right arithmetically by unsigned B; vacated bits filled with A[NBITS-1].
- `000010` SRL: A shifted right logically by unsigned B; vacated bits filled with 0.
- Any other code (including `000000`): result is all ones, {NBITS{1'b1}}.

Shift rules:
- The full B value is the shift amount, with no truncation to log2(NBITS) bits.
- If B ≥ NBITS, SRL yields 0.
- If B ≥ NBITS, SRA yields all copies of A[NBITS-1].

Other rules:
- Operands are unsigned for ADD, SUB, SRL and the logic ops. A is signed only for SRA sign fill.
- No status flags; overflow is silently dropped.
- Next-result logic is purely combinational from the inputs. The only state is the `ALU_Result` register.

## Timing
- Reset value: `ALU_Result` = 0.
- Reset is asynchronous: asserting `reset` clears `ALU_Result` immediately, independent of `clk`.
- While `reset` is high, `ALU_Result` holds 0 and rising edges have no effect.
- After `reset` deasserts, the first rising edge loads a computed result.
- Latency is 1 cycle. The inputs present at rising edge N determine `ALU_Result` from edge N until edge N+1.
- Inputs must be stable for setup/hold around the rising edge.
- New operands and opcode can be applied every cycle (throughput of 1 per cycle). There is no handshake and no valid signal.
- If reset is asserted mid-stream, the result in flight is lost and the output reads 0. Operation resumes on the first edge after release.
- `ALU_Result` changes only on a rising edge or on reset assertion. No combinational path from inputs to output.

## Test plan
NBITS = 8. Each check is made after the rising edge that samples the stimulus.
- Reset: assert `reset` with random inputs and clock running -> `ALU_Result` = 0x00 immediately and while held. Release and apply ADD 0x05+0x03 -> 0x08 after the next edge.
- Arithmetic wrap:
  - ADD 0xF0+0x20 -> 0x10.
  - SUB 0x03−0x05 -> 0xFE.
  - SUB 0x80−0x01 -> 0x7F.
- Logic, with A = 0xCA, B = 0x5C:
  - AND -> 0x48.
  - OR -> 0xDE.
  - XOR -> 0x96.
  - NOR -> 0x21.
- Shifts:
  - SRA 0x90 by 2 -> 0xE4.
  - SRL 0x90 by 2 -> 0x24.
  - SRA 0x90 by 9 -> 0xFF.
  - SRL 0x90 by 200 -> 0x00.
  - SRA 0x70 by 3 -> 0x0E.
- Invalid codes: `000000`, `111111` and `100001`, each with any A and B -> 0xFF.
- Random regression: each cycle, random A, B and a cyclic opcode sequence (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR, invalid). Compare the output against a reference model delayed by one cycle, for at least 1000 cycles, with zero mismatches.

Source files
------------

// File: rtl/alu.sv
// Registered integer ALU: eight MIPS-style function codes over two NBITS operands.
// The result register is the only state; everything ahead of it is combinational.
module alu #(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBITS-1:0]  operando_A,
  input  logic [NBITS-1:0]  operando_B,
  input  logic [COD_OP-1:0] cod_operacion,
  output logic [NBITS-1:0]  ALU_Result
);

  localparam logic [COD_OP-1:0] OP_ADD = COD_OP'(6'b100000);
  localparam logic [COD_OP-1:0] OP_SUB = COD_OP'(6'b100010);
  localparam logic [COD_OP-1:0] OP_AND = COD_OP'(6'b100100);
  localparam logic [COD_OP-1:0] OP_OR  = COD_OP'(6'b100101);
  localparam logic [COD_OP-1:0] OP_XOR = COD_OP'(6'b100110);
  localparam logic [COD_OP-1:0] OP_NOR = COD_OP'(6'b100111);
  localparam logic [COD_OP-1:0] OP_SRA = COD_OP'(6'b000011);
  localparam logic [COD_OP-1:0] OP_SRL = COD_OP'(6'b000010);

  // No handshake: a new operand/opcode set is accepted on every rising edge
  // and its result is visible from that edge until the next one.
  logic [NBITS-1:0] result_d;
  logic [NBITS-1:0] result_q;
  logic [NBITS-1:0] sra_res;
  logic [NBITS-1:0] srl_res;

  // The whole of operando_B is the shift amount; amounts >= NBITS saturate
  // to all-zero (logical) or all-sign (arithmetic).
  always_comb begin
    srl_res = operando_A >> operando_B;
    sra_res = $unsigned($signed(operando_A) >>> operando_B);
  end

  always_comb begin
    result_d = {NBITS{1'b1}};
    unique case (cod_operacion)
      OP_ADD:  result_d = operando_A + operando_B;
      OP_SUB:  result_d = operando_A - operando_B;
      OP_AND:  result_d = operando_A & operando_B;
      OP_OR:   result_d = operando_A | operando_B;
      OP_XOR:  result_d = operando_A ^ operando_B;
      OP_NOR:  result_d = ~(operando_A | operando_B);
      OP_SRA:  result_d = sra_res;
      OP_SRL:  result_d = srl_res;
      default: result_d = {NBITS{1'b1}};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) result_q <= '0;
    else       result_q <= result_d;
  end

  assign ALU_Result = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (NBITS = 8): directed vectors plus a cyclic-opcode
// random run, with expected results queued at drive time and popped after each edge.
module tb_alu;

  localparam int W = 8;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  logic         clk;
  logic         reset;
  logic [W-1:0] operando_A;
  logic [W-1:0] operando_B;
  logic [5:0]   cod_operacion;
  logic [W-1:0] ALU_Result;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  alu #(.NBITS(W), .COD_OP(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .operando_A    (operando_A),
    .operando_B    (operando_B),
    .cod_operacion (cod_operacion),
    .ALU_Result    (ALU_Result)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, written bit by bit for the shifts.
  function automatic logic [W-1:0] model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [5:0] op);
    logic [W-1:0] r;
    int idx;
    r = '1;
    case (op)
      OP_ADD: r = W'(a + b);
      OP_SUB: r = W'(a - b);
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SRA, OP_SRL: begin
        for (int i = 0; i < W; i++) begin
          idx = i + int'(b);
          if (idx < W)          r[i] = a[idx];
          else if (op == OP_SRA) r[i] = a[W-1];
          else                   r[i] = 1'b0;
        end
      end
      default: r = '1;
    endcase
    return r;
  endfunction

  // driver tasks
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op,
                       input logic [W-1:0] exp);
    operando_A    = a;
    operando_B    = b;
    cod_operacion = op;
    exp_q.push_back(exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] got, exp;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      operando_A    = W'($urandom_range(0, 255));
      operando_B    = W'($urandom_range(0, 255));
      cod_operacion = 6'($urandom_range(0, 63));
      step();
      n_checks++;
      if (ALU_Result !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected 00", i, ALU_Result);
      end
    end
    reset = 1'b0;
    drive(8'h05, 8'h03, OP_ADD, 8'h08);
    step();
    got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_release_add: got %h expected %h", got, exp);
    end
    drive(8'h12, 8'h34, 6'b000000, 8'hFF);
    step();
    got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL pre_midreset: got %h expected %h", got, exp);
    end
    // Mid-cycle assertion must clear the output without waiting for an edge.
    drive(8'h01, 8'h01, OP_ADD, 8'h02);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (ALU_Result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 00", ALU_Result);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (ALU_Result !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mid_hold[%0d]: got %h expected 00", i, ALU_Result);
      end
    end
    reset = 1'b0;
    drive(8'h0A, 8'h07, OP_SUB, 8'h03);
    step();
    got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_resume: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] a_t [3];
    logic [W-1:0] b_t [3];
    logic [5:0]   o_t [3];
    logic [W-1:0] e_t [3];
    logic [W-1:0] got, exp;
    a_t = '{8'hF0, 8'h03, 8'h80};
    b_t = '{8'h20, 8'h05, 8'h01};
    o_t = '{OP_ADD, OP_SUB, OP_SUB};
    e_t = '{8'h10, 8'hFE, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      drive(a_t[i], b_t[i], o_t[i], e_t[i]);
      step();
      got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL arith[%0d] %h op %b %h: got %h expected %h", i, a_t[i], o_t[i], b_t[i], got, exp);
      end
    end
  endtask

  task automatic test_logic();
    logic [5:0]   o_t [4];
    logic [W-1:0] e_t [4];
    logic [W-1:0] got, exp;
    o_t = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
    e_t = '{8'h48, 8'hDE, 8'h96, 8'h21};
    for (int i = 0; i < 4; i++) begin
      drive(8'hCA, 8'h5C, o_t[i], e_t[i]);
      step();
      got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL logic[%0d] op %b: got %h expected %h", i, o_t[i], got, exp);
      end
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] a_t [5];
    logic [W-1:0] b_t [5];
    logic [5:0]   o_t [5];
    logic [W-1:0] e_t [5];
    logic [W-1:0] got, exp;
    a_t = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h70};
    b_t = '{8'd2, 8'd2, 8'd9, 8'd200, 8'd3};
    o_t = '{OP_SRA, OP_SRL, OP_SRA, OP_SRL, OP_SRA};
    e_t = '{8'hE4, 8'h24, 8'hFF, 8'h00, 8'h0E};
    for (int i = 0; i < 5; i++) begin
      drive(a_t[i], b_t[i], o_t[i], e_t[i]);
      step();
      got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL shift[%0d] %h op %b by %0d: got %h expected %h", i, a_t[i], o_t[i], b_t[i], got, exp);
      end
    end
  endtask

  task automatic test_invalid();
    logic [5:0]   o_t [3];
    logic [W-1:0] got, exp;
    o_t = '{6'b000000, 6'b111111, 6'b100001};
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), o_t[i], 8'hFF);
      step();
      got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL invalid[%0d] op %b: got %h expected %h", i, o_t[i], got, exp);
      end
    end
  endtask

  // Back-to-back random run: one new operation every cycle.
  task automatic test_random();
    logic [5:0]   seq [9];
    logic [W-1:0] a, b, got, exp;
    logic [5:0]   op;
    int           errs;
    seq  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, 6'b000000};
    errs = 0;
    for (int i = 0; i < 1080; i++) begin
      a  = W'($urandom_range(0, 255));
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, 255));
      op = seq[i % 9];
      if (i % 9 == 8) begin
        op = 6'($urandom_range(0, 63));
        while (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR || op == OP_XOR ||
               op == OP_NOR || op == OP_SRA || op == OP_SRL)
          op = 6'($urandom_range(0, 63));
      end
      drive(a, b, op, model_alu(a, b, op));
      step();
      got = ALU_Result; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d] %h op %b %h: got %h expected %h", i, a, op, b, got, exp);
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    operando_A    = '0;
    operando_B    = '0;
    cod_operacion = '0;
    #1;
    n_checks++;
    if (ALU_Result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected 00", ALU_Result);
    end
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_invalid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
